gambit_tail_ctrl: RTL and testbench

- Owns the issue-queue (IQ) tail pointers, the reorder-buffer (ROB) tail and head pointers, and the ROB occupancy count.
- Feeds the per-slot tail vectors that the queue-count logic uses to check slot availability and decide how many instructions queue this cycle.
- Advances pointers by the queued and committed counts each cycle.
- Rolls tails back on a branch miss and stalls queuing for one recovery cycle.

---
 rtl/gambit_tail_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_gambit_tail_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gambit_tail_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gambit_tail_ctrl
// Purpose  : Sequences the issue-queue tail pointers, the reorder-buffer tail
//            and head pointers and the ROB occupancy count. Pointers advance
//            by the queued/committed counts each cycle; on a branch miss the
//            tails roll back behind the mispredicted branch and queuing is
//            stalled for one recovery cycle.
// Ports    : clk, rst_n            clock, async active-low reset
//            queued_cnt            instructions queued this cycle
//            commit_cnt            ROB entries retired this cycle
//            branchmiss            branch-miss pulse
//            miss_qid, miss_rid    IQ / ROB index of the mispredicted branch
//            tails, rob_tails      per-slot IQ / ROB tail pointers
//            rob_head, rob_count   oldest ROB entry / ROB occupancy
//            rob_full              fewer than RSLOTS entries free
//            stall                 queuing inhibited (recovery cycle)
//            err                   sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
module gambit_tail_ctrl #(
    parameter int IQ_ENTRIES = 8,
    parameter int RENTRIES   = 16,
    parameter int QSLOTS     = 3,
    parameter int RSLOTS     = 3,
    parameter int QB         = $clog2(IQ_ENTRIES),
    parameter int RB         = $clog2(RENTRIES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2:0]                   queued_cnt,
    input  logic [2:0]                   commit_cnt,
    input  logic                         branchmiss,
    input  logic [QB-1:0]                miss_qid,
    input  logic [RB-1:0]                miss_rid,
    output logic [QSLOTS-1:0][QB-1:0]    tails,
    output logic [RSLOTS-1:0][RB-1:0]    rob_tails,
    output logic [RB-1:0]                rob_head,
    output logic [RB:0]                  rob_count,
    output logic                         rob_full,
    output logic                         stall,
    output logic                         err
);

    localparam logic [QB:0] c_iq_depth  = (QB+1)'(IQ_ENTRIES);
    localparam logic [RB:0] c_rob_depth = (RB+1)'(RENTRIES);
    localparam logic [RB:0] c_full_thr  = (RB+1)'(RENTRIES - RSLOTS);
    localparam logic [RB:0] c_qslots    = (RB+1)'(QSLOTS);
    localparam logic [2:0]  c_qslots3   = 3'(QSLOTS);

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_RECOVER = 1'b1
    } state_t;

    // Depth need not be a power of two, so wrap by a single conditional
    // subtract (both operands are always below the depth).
    function automatic logic [QB-1:0] iq_add(input logic [QB-1:0] a, input logic [QB-1:0] b);
        logic [QB:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_iq_depth) begin
            return QB'(s - c_iq_depth);
        end
        return QB'(s);
    endfunction

    function automatic logic [RB-1:0] rob_add(input logic [RB-1:0] a, input logic [RB-1:0] b);
        logic [RB:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_rob_depth) begin
            return RB'(s - c_rob_depth);
        end
        return RB'(s);
    endfunction

    // Distance from b forward to a around the ROB ring.
    function automatic logic [RB-1:0] rob_sub(input logic [RB-1:0] a, input logic [RB-1:0] b);
        if (a >= b) begin
            return a - b;
        end
        return RB'({1'b0, a} + c_rob_depth - {1'b0, b});
    endfunction

    state_t                       r_state;
    logic                         r_stall;
    logic                         r_err;
    logic [QSLOTS-1:0][QB-1:0]    r_tails;
    logic [RSLOTS-1:0][RB-1:0]    r_rob_tails;
    logic [RB-1:0]                r_head;
    logic [RB:0]                  r_count;

    logic [RB:0]   w_q_req;
    logic [RB:0]   w_q;
    logic [RB:0]   w_c;
    logic [RB:0]   w_free;
    logic          w_over;
    logic [RB-1:0] w_head_nxt;
    logic [RB-1:0] w_miss_off;
    logic [RB-1:0] w_dist;
    logic          w_br_commits;
    logic [QB-1:0] w_tail0_nxt;
    logic [RB-1:0] w_rtail0_nxt;
    logic [RB:0]   w_count_nxt;
    logic          w_err;

    always_comb begin
        // Clamp the requested counts so the pointers stay coherent even when
        // the producer violates the protocol.
        w_q_req    = (queued_cnt > c_qslots3) ? c_qslots : (RB+1)'(queued_cnt);
        w_c        = ((RB+1)'(commit_cnt) > r_count) ? r_count : (RB+1)'(commit_cnt);
        // Same-cycle commits free entries, so the clamp credits them.
        w_free     = c_rob_depth - r_count + w_c;
        w_q        = (w_q_req > w_free) ? w_free : w_q_req;
        // Upstream sizes its queue against the registered count, so asking
        // for more than is currently free is a protocol violation even when
        // same-cycle commits happen to make room.
        w_over     = ({1'b0, r_count} + {1'b0, w_q_req}) > {1'b0, c_rob_depth};
        w_head_nxt = rob_add(r_head, w_c[RB-1:0]);

        // The branch retires this cycle if it lies within the committed run.
        w_miss_off   = rob_sub(miss_rid, r_head);
        w_br_commits = ({1'b0, w_miss_off} < w_c);
        w_dist       = rob_sub(miss_rid, w_head_nxt);

        w_tail0_nxt  = r_tails[0];
        w_rtail0_nxt = r_rob_tails[0];
        w_count_nxt  = r_count - w_c;
        w_err        = ((RB+1)'(commit_cnt) > r_count);

        if (branchmiss) begin
            w_tail0_nxt = iq_add(miss_qid, QB'(1));
            if (w_br_commits) begin
                w_rtail0_nxt = w_head_nxt;
                w_count_nxt  = '0;
            end else begin
                w_rtail0_nxt = rob_add(miss_rid, RB'(1));
                w_count_nxt  = {1'b0, w_dist} + (RB+1)'(1);
            end
        end else if (r_state == S_RUN) begin
            w_tail0_nxt  = iq_add(r_tails[0], w_q[QB-1:0]);
            w_rtail0_nxt = rob_add(r_rob_tails[0], w_q[RB-1:0]);
            w_count_nxt  = r_count + w_q - w_c;
        end

        if (r_state == S_RECOVER) begin
            w_err = w_err || (queued_cnt != 3'd0);
        end else if (!branchmiss) begin
            w_err = w_err || (queued_cnt > c_qslots3) || w_over;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QSLOTS; i++) begin
                r_tails[i] <= QB'(i);
            end
            for (int i = 0; i < RSLOTS; i++) begin
                r_rob_tails[i] <= RB'(i);
            end
            r_head  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_stall <= 1'b0;
            r_state <= S_RUN;
        end else begin
            // Every slot is re-derived from slot 0 so the vectors never skew.
            for (int i = 0; i < QSLOTS; i++) begin
                r_tails[i] <= iq_add(w_tail0_nxt, QB'(i));
            end
            for (int i = 0; i < RSLOTS; i++) begin
                r_rob_tails[i] <= rob_add(w_rtail0_nxt, RB'(i));
            end
            r_head  <= w_head_nxt;
            r_count <= w_count_nxt;
            r_err   <= r_err | w_err;
            case (r_state)
                S_RUN: begin
                    if (branchmiss) begin
                        r_state <= S_RECOVER;
                        r_stall <= 1'b1;
                    end
                end
                S_RECOVER: begin
                    // A further miss re-applies the rollback and holds here.
                    if (!branchmiss) begin
                        r_state <= S_RUN;
                        r_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign tails     = r_tails;
    assign rob_tails = r_rob_tails;
    assign rob_head  = r_head;
    assign rob_count = r_count;
    assign rob_full  = (r_count > c_full_thr);
    assign stall     = r_stall;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gambit_tail_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gambit_tail_ctrl
// Purpose  : Self-checking bench for gambit_tail_ctrl. A behavioural model
//            predicts the full output state for every driven cycle; the
//            prediction is queued and compared one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gambit_tail_ctrl;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       queued_cnt = '0;
    logic [2:0]       commit_cnt = '0;
    logic             branchmiss = 1'b0;
    logic [2:0]       miss_qid = '0;
    logic [3:0]       miss_rid = '0;
    logic [2:0][2:0]  tails;
    logic [2:0][3:0]  rob_tails;
    logic [3:0]       rob_head;
    logic [4:0]       rob_count;
    logic             rob_full;
    logic             stall;
    logic             err;

    gambit_tail_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .queued_cnt (queued_cnt),
        .commit_cnt (commit_cnt),
        .branchmiss (branchmiss),
        .miss_qid   (miss_qid),
        .miss_rid   (miss_rid),
        .tails      (tails),
        .rob_tails  (rob_tails),
        .rob_head   (rob_head),
        .rob_count  (rob_count),
        .rob_full   (rob_full),
        .stall      (stall),
        .err        (err)
    );

    always #5 clk = ~clk;

    wire [32:0] obs = {tails, rob_tails, rob_head, rob_count, rob_full, stall, err};
    localparam logic [32:0] c_rst = {9'b010_001_000, 12'h210, 4'd0, 5'd0, 3'b000};

    int total = 0;
    int bad   = 0;
    logic [32:0] sbq[$];
    logic [32:0] e;

    // Behavioural model (IQ depth 8, ROB depth 16, 3 slots).
    int m_tail, m_rtail, m_head, m_count;
    bit m_rec, m_err;

    function automatic void model_reset();
        m_tail = 0; m_rtail = 0; m_head = 0; m_count = 0; m_rec = 0; m_err = 0;
    endfunction

    function automatic void model_step(input int q, input int c, input bit bm, input int qid, input int rid);
        int cc, nh, qq, fr;
        bit ev;
        ev = 0;
        cc = c;
        if (c > m_count) begin ev = 1; cc = m_count; end
        nh = (m_head + cc) % 16;
        if (m_rec && q != 0) ev = 1;
        if (bm) begin
            m_tail = (qid + 1) % 8;
            if (((rid - m_head + 16) % 16) < cc) begin
                m_rtail = nh; m_count = 0;
            end else begin
                m_rtail = (rid + 1) % 16;
                m_count = ((rid - nh + 16) % 16) + 1;
            end
            m_rec = 1;
        end else if (m_rec) begin
            m_count = m_count - cc;
            m_rec = 0;
        end else begin
            qq = (q > 3) ? 3 : q;
            if (q > 3) ev = 1;
            if (m_count + qq > 16) ev = 1;
            fr = 16 - m_count + cc;
            if (qq > fr) qq = fr;
            m_tail  = (m_tail + qq) % 8;
            m_rtail = (m_rtail + qq) % 16;
            m_count = m_count + qq - cc;
        end
        m_head = nh;
        m_err = m_err | ev;
    endfunction

    function automatic logic [32:0] model_exp();
        logic [8:0]  t;
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            t[i*3 +: 3] = 3'((m_tail + i) % 8);
            r[i*4 +: 4] = 4'((m_rtail + i) % 16);
        end
        return {t, r, 4'(m_head), 5'(m_count), (m_count > 13), m_rec, m_err};
    endfunction

    // Drive one cycle of stimulus, record the prediction, step past the edge.
    task automatic drive(input int q, input int c, input bit bm, input int qid, input int rid);
        queued_cnt = 3'(q);
        commit_cnt = 3'(c);
        branchmiss = bm;
        miss_qid   = 3'(qid);
        miss_rid   = 4'(rid);
        model_step(q, c, bm, qid, rid);
        sbq.push_back(model_exp());
        @(posedge clk);
        #1;
        queued_cnt = '0;
        commit_cnt = '0;
        branchmiss = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        queued_cnt = '0; commit_cnt = '0; branchmiss = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        sbq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (obs !== c_rst) begin
            bad++; $display("FAIL reset_state got=%h want=%h", obs, c_rst);
        end
    endtask

    task automatic test_reset_midrun();
        int qs[2] = '{3, 2};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive(qs[i], 0, 0, 0, 0);
            e = sbq.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL midrun[%0d] got=%h want=%h", i, obs, e); end
        end
        total++;
        if (tails[0] !== 3'd5) begin bad++; $display("FAIL midrun_tail got=%0d want=5", tails[0]); end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== c_rst || stall !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%h want=%h", obs, c_rst);
        end
        apply_reset();
    endtask

    task automatic test_iq_wrap();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(3, 0, 0, 0, 0);
            e = sbq.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL wrap[%0d] got=%h want=%h", i, obs, e); end
        end
        total++;
        if (tails !== {3'd3, 3'd2, 3'd1} || rob_tails[0] !== 4'd9 || rob_count !== 5'd9) begin
            bad++; $display("FAIL wrap_vals got tails=%h rt0=%0d cnt=%0d want tails=0d1 rt0=9 cnt=9",
                            tails, rob_tails[0], rob_count);
        end
    endtask

    task automatic test_rob_fill();
        int qs[8] = '{3, 3, 3, 3, 3, 3, 0, 3};
        int cs[8] = '{0, 0, 0, 0, 0, 2, 3, 3};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(qs[i], cs[i], 0, 0, 0);
            e = sbq.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL fill[%0d] got=%h want=%h", i, obs, e); end
            if (i == 4) begin
                total++;
                if (rob_count !== 5'd15 || rob_full !== 1'b1) begin
                    bad++; $display("FAIL fill15 got cnt=%0d full=%b want cnt=15 full=1", rob_count, rob_full);
                end
            end
            if (i == 5) begin
                total++;
                if (err !== 1'b1 || rob_count !== 5'd16 || rob_tails[0] !== rob_head) begin
                    bad++; $display("FAIL overfill got err=%b cnt=%0d rt0=%0d head=%0d want err=1 cnt=16 rt0=head",
                                    err, rob_count, rob_tails[0], rob_head);
                end
            end
            if (i == 6) begin
                total++;
                if (rob_count !== 5'd13 || rob_full !== 1'b0) begin
                    bad++; $display("FAIL drain13 got cnt=%0d full=%b want cnt=13 full=0", rob_count, rob_full);
                end
            end
        end
    endtask

    task automatic test_branch_miss();
        int qs[6] = '{3, 3, 3, 3, 0, 0};
        int cs[6] = '{0, 0, 0, 0, 2, 1};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(qs[i], cs[i], (i == 5), 4, 9);
            e = sbq.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL miss[%0d] got=%h want=%h", i, obs, e); end
        end
        total++;
        if (rob_tails[0] !== 4'd10 || tails[0] !== 3'd5 || rob_head !== 4'd3 || rob_count !== 5'd7 || stall !== 1'b1) begin
            bad++; $display("FAIL miss_vals got rt0=%0d t0=%0d head=%0d cnt=%0d stall=%b want 10 5 3 7 1",
                            rob_tails[0], tails[0], rob_head, rob_count, stall);
        end
        drive(0, 0, 0, 0, 0);
        e = sbq.pop_front(); total++;
        if (obs !== e || stall !== 1'b0) begin bad++; $display("FAIL miss_exit got=%h want=%h", obs, e); end
    endtask

    task automatic test_back_to_back();
        int bms[5]  = '{1, 1, 0, 1, 0};
        int qids[5] = '{1, 7, 0, 0, 0};
        int rids[5] = '{8, 5, 0, 3, 0};
        int cs[5]   = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drive(0, cs[i], bms[i][0], qids[i], rids[i]);
            e = sbq.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL b2b[%0d] got=%h want=%h", i, obs, e); end
            if (i == 1) begin
                total++;
                if (rob_tails[0] !== 4'd6 || stall !== 1'b1 || tails[0] !== 3'd0) begin
                    bad++; $display("FAIL b2b_second got rt0=%0d stall=%b t0=%0d want 6 1 0", rob_tails[0], stall, tails[0]);
                end
            end
            if (i == 3) begin
                total++;
                if (rob_count !== 5'd0 || rob_tails[0] !== rob_head || rob_head !== 4'd4) begin
                    bad++; $display("FAIL miss_commit got cnt=%0d rt0=%0d head=%0d want 0 4 4", rob_count, rob_tails[0], rob_head);
                end
            end
        end
    endtask

    task automatic test_protocol_err();
        int qs[6]  = '{3, 0, 2, 0, 0, 5};
        int bms[6] = '{0, 1, 0, 0, 0, 0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(qs[i], 0, bms[i][0], 2, 1);
            e = sbq.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL perr[%0d] got=%h want=%h", i, obs, e); end
            if (i == 2) begin
                total++;
                if (err !== 1'b1 || tails[0] !== 3'd3 || stall !== 1'b0) begin
                    bad++; $display("FAIL rec_queue got err=%b t0=%0d stall=%b want 1 3 0", err, tails[0], stall);
                end
            end
        end
        apply_reset();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
        drive(0, 2, 0, 0, 0);
        e = sbq.pop_front(); total++;
        if (obs !== e || err !== 1'b1 || rob_count !== 5'd0) begin
            bad++; $display("FAIL over_commit got=%h want=%h", obs, e);
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_iq_wrap();
        test_rob_fill();
        test_branch_miss();
        test_back_to_back();
        test_protocol_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
